// File: rtl/alu_md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md_pkg                                                           |
// | Op codes and shared types for the integer execute unit (ALU + M).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_md_pkg;

  localparam int ALU_OP_WIDTH = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 5'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 5'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 5'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHL    = 5'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHR    = 5'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHRA   = 5'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ     = 5'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NEQ    = 5'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LT     = 5'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU    = 5'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GE     = 5'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU    = 5'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd16;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd17;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd18;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd19;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd20;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd21;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd22;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd23;

  // Which slice of the iterative datapath becomes the M-op result
  typedef enum logic [1:0] {
    SEL_MUL_LO = 2'd0,
    SEL_MUL_HI = 2'd1,
    SEL_QUO    = 2'd2,
    SEL_REM    = 2'd3
  } md_sel_e;

endpackage
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md_iter                                                          |
// | Shared radix-2 shift-add multiplier / restoring divider on unsigned  |
// | magnitudes; XLEN steps per operation. Revision: 1.0                  |
// +----------------------------------------------------------------------+
module alu_md_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              abort,
  input  logic              start,
  input  logic              mode,      // 0: multiply, 1: divide
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder,
  output logic              done
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] c_last = CW'(XLEN - 1);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_mode;

  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_step;

  // Multiply: multiplier sits in the low half and shifts out as partial sums shift in.
  // Divide: {remainder, quotient} shift left, one quotient bit per step.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_shift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_b};

  always_comb begin
    w_step = {w_mul_sum, r_acc[XLEN-1:1]};
    if (r_mode) begin
      if (w_diff[XLEN]) w_step = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      else              w_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_mode <= 1'b0;
    end else if (en) begin
      if (abort) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (start) begin
        r_acc  <= {{XLEN{1'b0}}, mag_a};
        r_b    <= mag_b;
        r_mode <= mode;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_last) r_busy <= 1'b0;
      end
    end
  end

  assign done      = r_busy && (r_cnt == c_last);
  assign product   = r_acc;
  assign quotient  = r_acc[XLEN-1:0];
  assign remainder = r_acc[2*XLEN-1:XLEN];

endmodule
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md                                                               |
// | Integer execute unit: 1-cycle base ALU ops plus iterative RV32M ops. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_md
  import alu_md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = ALU_OP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             flush,
  input  logic             rs_valid,
  input  logic [OP_W-1:0]  rs_op,
  input  logic [XLEN-1:0]  rs_val1,
  input  logic [XLEN-1:0]  rs_val2,
  input  logic [ROB_W-1:0] rs_id,
  output logic             alu_accept,
  output logic             alu_ready,
  output logic [XLEN-1:0]  alu_res,
  output logic [ROB_W-1:0] alu_id
);

  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mul  = 2'd1;
  localparam logic [1:0] c_st_div  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;
  localparam logic [XLEN-1:0] c_min = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]              r_state, w_next;
  logic                    r_ready, r_qneg, r_rneg;
  logic [XLEN-1:0]         r_res;
  logic [ROB_W-1:0]        r_id, r_mid;
  md_sel_e                 r_sel, w_sel;

  logic [ALU_OP_WIDTH-1:0] w_op;
  logic                    w_op_ok, w_issue, w_m_start;
  logic                    w_is_mul, w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic                    w_div0, w_ovf, w_special;
  logic [SW-1:0]           w_sh;
  logic [XLEN-1:0]         w_base_res, w_spec_res, w_mag1, w_mag2, w_fin;
  logic [XLEN-1:0]         w_quo, w_rem;
  logic [2*XLEN-1:0]       w_prod, w_prod_c;
  logic                    w_done;

  assign w_op      = ALU_OP_WIDTH'(rs_op);
  assign w_op_ok   = (OP_W'(w_op) == rs_op);
  assign w_sh      = rs_val2[SW-1:0];
  assign w_issue   = rdy && rs_valid && alu_accept && !flush;
  assign w_m_start = w_issue && (w_is_mul || (w_is_div && !w_special));

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_sgn1   = 1'b0;
    w_sgn2   = 1'b0;
    w_sel    = SEL_MUL_LO;
    if (w_op_ok) begin
      case (w_op)
        ALU_MUL:    begin w_is_mul = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; end
        ALU_MULH:   begin w_is_mul = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_sel = SEL_MUL_HI; end
        ALU_MULHSU: begin w_is_mul = 1'b1; w_sgn1 = 1'b1; w_sel = SEL_MUL_HI; end
        ALU_MULHU:  begin w_is_mul = 1'b1; w_sel = SEL_MUL_HI; end
        ALU_DIV:    begin w_is_div = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_sel = SEL_QUO; end
        ALU_DIVU:   begin w_is_div = 1'b1; w_sel = SEL_QUO; end
        ALU_REM:    begin w_is_div = 1'b1; w_sgn1 = 1'b1; w_sgn2 = 1'b1; w_sel = SEL_REM; end
        ALU_REMU:   begin w_is_div = 1'b1; w_sel = SEL_REM; end
        default:    ;
      endcase
    end
  end

  assign w_neg1 = w_sgn1 && rs_val1[XLEN-1];
  assign w_neg2 = w_sgn2 && rs_val2[XLEN-1];
  assign w_mag1 = w_neg1 ? (~rs_val1 + 1'b1) : rs_val1;
  assign w_mag2 = w_neg2 ? (~rs_val2 + 1'b1) : rs_val2;

  // Divide cases the iterative datapath cannot answer resolve in one cycle
  assign w_div0    = w_is_div && (rs_val2 == '0);
  assign w_ovf     = w_is_div && w_sgn1 && (rs_val1 == c_min) && (&rs_val2);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div0)     w_spec_res = (w_sel == SEL_QUO) ? '1 : rs_val1;
    else if (w_ovf) w_spec_res = (w_sel == SEL_QUO) ? rs_val1 : '0;
  end

  always_comb begin
    w_base_res = '0;
    if (w_op_ok) begin
      case (w_op)
        ALU_ADD:  w_base_res = rs_val1 + rs_val2;
        ALU_SUB:  w_base_res = rs_val1 - rs_val2;
        ALU_AND:  w_base_res = rs_val1 & rs_val2;
        ALU_OR:   w_base_res = rs_val1 | rs_val2;
        ALU_XOR:  w_base_res = rs_val1 ^ rs_val2;
        ALU_SHL:  w_base_res = rs_val1 << w_sh;
        ALU_SHR:  w_base_res = rs_val1 >> w_sh;
        ALU_SHRA: w_base_res = $signed(rs_val1) >>> w_sh;
        ALU_EQ:   w_base_res = XLEN'(rs_val1 == rs_val2);
        ALU_NEQ:  w_base_res = XLEN'(rs_val1 != rs_val2);
        ALU_LT:   w_base_res = XLEN'($signed(rs_val1) < $signed(rs_val2));
        ALU_LTU:  w_base_res = XLEN'(rs_val1 < rs_val2);
        ALU_GE:   w_base_res = XLEN'($signed(rs_val1) >= $signed(rs_val2));
        ALU_GEU:  w_base_res = XLEN'(rs_val1 >= rs_val2);
        default:  w_base_res = '0;
      endcase
    end
  end

  alu_md_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (rdy),
    .abort     (flush),
    .start     (w_m_start),
    .mode      (w_is_div),
    .mag_a     (w_mag1),
    .mag_b     (w_mag2),
    .product   (w_prod),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_done)
  );

  // Quotient and product share one sign flag; remainder follows the dividend
  assign w_prod_c = r_qneg ? (~w_prod + 1'b1) : w_prod;

  always_comb begin
    case (r_sel)
      SEL_MUL_LO: w_fin = w_prod_c[XLEN-1:0];
      SEL_MUL_HI: w_fin = w_prod_c[2*XLEN-1:XLEN];
      SEL_QUO:    w_fin = r_qneg ? (~w_quo + 1'b1) : w_quo;
      default:    w_fin = r_rneg ? (~w_rem + 1'b1) : w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= c_st_idle;
    else if (rdy) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (w_m_start) w_next = w_is_mul ? c_st_mul : c_st_div;
        c_st_mul,
        c_st_div:  if (w_done) w_next = c_st_done;
        default:   w_next = c_st_idle;
      endcase
    end
  end

  always_comb begin
    alu_accept = (r_state == c_st_idle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_res   <= '0;
      r_id    <= '0;
      r_mid   <= '0;
      r_sel   <= SEL_MUL_LO;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else if (rdy) begin
      r_ready <= 1'b0;
      if (w_m_start) begin
        r_mid  <= rs_id;
        r_sel  <= w_sel;
        r_qneg <= w_neg1 ^ w_neg2;
        r_rneg <= w_neg1;
      end else if (w_issue) begin
        r_ready <= 1'b1;
        r_res   <= w_is_div ? w_spec_res : w_base_res;
        r_id    <= rs_id;
      end else if (!flush && r_state == c_st_done) begin
        r_ready <= 1'b1;
        r_res   <= w_fin;
        r_id    <= r_mid;
      end
    end
  end

  assign alu_ready = r_ready;
  assign alu_res   = r_res;
  assign alu_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_md                                                            |
// | Scoreboard bench: directed ops push expectations, a monitor checks.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_md;
  import alu_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        rs_valid = 1'b0;
  logic [4:0]  rs_op = '0;
  logic [31:0] rs_val1 = '0;
  logic [31:0] rs_val2 = '0;
  logic [3:0]  rs_id = '0;
  logic        alu_accept, alu_ready;
  logic [31:0] alu_res;
  logic [3:0]  alu_id;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  id;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic rdy_q = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  alu_md dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .flush      (flush),
    .rs_valid   (rs_valid),
    .rs_op      (rs_op),
    .rs_val1    (rs_val1),
    .rs_val2    (rs_val2),
    .rs_id      (rs_id),
    .alu_accept (alu_accept),
    .alu_ready  (alu_ready),
    .alu_res    (alu_res),
    .alu_id     (alu_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_q <= rdy;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A result is new when the edge that produced it was enabled
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_ready && rdy_q) begin
        if (q.size() == 0) begin
          check("unexpected_result", {32'h0, alu_res}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("res", {32'h0, alu_res}, {32'h0, e.res});
          check("id", {60'h0, alu_id}, {60'h0, e.id});
          check("latency", 64'(cyc), 64'(e.due));
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        check("missing_result_id", 64'(cyc), 64'(q[0].due));
        void'(q.pop_front());
      end
    end
  end

  // Called just after an edge; issues on the next edge and, if push, expects
  // the result lat cycles later (lat=1: visible right after the issue edge).
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] id, input logic [31:0] exp, input int lat, input bit push);
    int guard = 0;
    while (!alu_accept && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!alu_accept) check("accept_timeout", 64'h0, 64'h1);
    rs_valid = 1'b1; rs_op = op; rs_val1 = a; rs_val2 = b; rs_id = id;
    @(posedge clk); #1;
    rs_valid = 1'b0;
    if (push) q.push_back('{exp, id, cyc + lat - 1});
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    check("global_timeout", 64'h0, 64'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int n;
    #12;
    check("rst_ready", {63'h0, alu_ready}, 64'h0);
    check("rst_res", {32'h0, alu_res}, 64'h0);
    check("rst_id", {60'h0, alu_id}, 64'h0);
    check("rst_accept", {63'h0, alu_accept}, 64'h1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(ALU_ADD,  32'h7FFF_FFFF, 32'h1,          4'd3, 32'h8000_0000, 1, 1);
    send(ALU_SHRA, 32'h8000_0000, 32'h21,         4'd4, 32'hC000_0000, 1, 1);
    send(ALU_SUB,  32'h0,         32'h1,          4'd1, 32'hFFFF_FFFF, 1, 1);
    send(ALU_SHL,  32'h1,         32'h3F,         4'd2, 32'h8000_0000, 1, 1);
    send(ALU_SHR,  32'h8000_0000, 32'h4,          4'd2, 32'h0800_0000, 1, 1);
    send(ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00,  4'd8, 32'h0FF0_0FF0, 1, 1);
    send(ALU_LT,   32'hFFFF_FFFF, 32'h1,          4'd9, 32'h1,         1, 1);
    send(ALU_LTU,  32'hFFFF_FFFF, 32'h1,          4'd9, 32'h0,         1, 1);
    send(ALU_GEU,  32'hFFFF_FFFF, 32'h1,          4'd9, 32'h1,         1, 1);
    send(ALU_EQ,   32'h5,         32'h5,          4'd9, 32'h1,         1, 1);
    send(ALU_NEQ,  32'h5,         32'h5,          4'd9, 32'h0,         1, 1);
    send(5'd31,    32'h1234,      32'h5678,       4'd15, 32'h0,        1, 1);

    send(ALU_MULH, 32'hFFFF_FFF9, 32'h3, 4'd5, 32'hFFFF_FFFF, 34, 1);
    n = 0;
    while (!alu_accept && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("accept_low_cycles", 64'(n), 64'd33);
    send(ALU_MUL,    32'hFFFF_FFF9, 32'h3, 4'd6, 32'hFFFF_FFEB, 34, 1);
    send(ALU_MULHSU, 32'hFFFF_FFFF, 32'h2, 4'd7, 32'hFFFF_FFFF, 34, 1);
    send(ALU_MULHU,  32'hFFFF_FFFF, 32'h2, 4'd7, 32'h1,         34, 1);
    send(ALU_DIV,    32'hFFFF_FFF9, 32'h2, 4'd1, 32'hFFFF_FFFD, 34, 1);
    send(ALU_REM,    32'hFFFF_FFF9, 32'h2, 4'd2, 32'hFFFF_FFFF, 34, 1);
    send(ALU_DIVU,   32'd100,       32'd7, 4'd3, 32'd14,        34, 1);
    send(ALU_REMU,   32'd100,       32'd7, 4'd4, 32'd2,         34, 1);
    send(ALU_DIVU,   32'd7, 32'h0,         4'd10, 32'hFFFF_FFFF, 1, 1);
    send(ALU_REMU,   32'd7, 32'h0,         4'd11, 32'd7,         1, 1);
    send(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 32'h8000_0000, 1, 1);
    send(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 32'h0,         1, 1);

    // Flush at iteration 10 of a divide; the op offered in that cycle is dropped
    send(ALU_DIVU, 32'd100, 32'd7, 4'd14, 32'h0, 0, 0);
    tick(10);
    flush = 1'b1; rs_valid = 1'b1; rs_op = ALU_ADD; rs_val1 = 32'd9; rs_val2 = 32'd9; rs_id = 4'd14;
    tick(1);
    flush = 1'b0; rs_valid = 1'b0;
    check("flush_accept", {63'h0, alu_accept}, 64'h1);
    check("flush_no_ready", {63'h0, alu_ready}, 64'h0);
    send(ALU_ADD, 32'd1, 32'd2, 4'd9, 32'd3, 1, 1);

    // Flush while idle drops the presented op
    flush = 1'b1; rs_valid = 1'b1; rs_op = ALU_ADD; rs_val1 = 32'd4; rs_val2 = 32'd4; rs_id = 4'd2;
    tick(1);
    flush = 1'b0; rs_valid = 1'b0;
    check("idle_flush_drop", {63'h0, alu_ready}, 64'h0);

    // Flush in DONE suppresses the result
    send(ALU_MUL, 32'd100, 32'd7, 4'd8, 32'h0, 0, 0);
    tick(32);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("done_flush_no_ready", {63'h0, alu_ready}, 64'h0);
    check("done_flush_accept", {63'h0, alu_accept}, 64'h1);

    // Five stalled edges mid-multiply delay completion by five
    send(ALU_MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 4'd6, 32'hC, 39, 1);
    tick(10);
    rdy = 1'b0;
    tick(5);
    rdy = 1'b1;
    send(ALU_ADD, 32'd5, 32'd6, 4'd7, 32'hB, 1, 1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("ready_held", {63'h0, alu_ready}, 64'h1);
    end
    rdy = 1'b1;
    tick(1);
    check("ready_released", {63'h0, alu_ready}, 64'h0);

    // Asynchronous reset mid-divide
    send(ALU_DIV, 32'hFFFF_FFF9, 32'h2, 4'd11, 32'h0, 0, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ready", {63'h0, alu_ready}, 64'h0);
    check("async_rst_res", {32'h0, alu_res}, 64'h0);
    check("async_rst_id", {60'h0, alu_id}, 64'h0);
    #2 rst_n = 1'b1;
    tick(1);
    check("post_rst_accept", {63'h0, alu_accept}, 64'h1);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(3);
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_md.md
Name: alu_md

Overview:
- Next-generation integer execute unit, sitting between the ALU reservation station and the CDB/ROB writeback.
- Covers the base ALU op set plus the RV32M multiply/divide ops, parametrised in XLEN.
- Base ops complete in 1 cycle.
- MUL/DIV ops run on a shared iterative radix-2 datapath, with an accept handshake back-pressuring the RS.

Parameters:
XLEN, 32, datapath width (power of 2, >=8)
ROB_W, 4, ROB id width (ROB_SIZE_WIDTH)
OP_W, 5, op code width (ALU_OP_WIDTH, widened for M ops)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; low = every register holds
flush  in  1  mispredict flush, synchronous
rs_valid  in  1  RS presents an op this cycle
rs_op  in  OP_W  operation code
rs_val1  in  XLEN  operand 1
rs_val2  in  XLEN  operand 2
rs_id  in  ROB_W  ROB id of the op
alu_accept  out  1  unit can take an op; equals (state==IDLE), combinational
alu_ready  out  1  result valid, one-cycle pulse
alu_res  out  XLEN  result
alu_id  out  ROB_W  ROB id of the result

Behaviour:
- Reset (rst_n low, async): state=IDLE; alu_ready=0; alu_res=0; alu_id=0; counter and working registers cleared.
- rdy low: all state and outputs hold, including alu_ready.
- An op issues on an edge where rdy & rs_valid & alu_accept & !flush.
- Base ops: ADD SUB AND OR XOR SHL SHR SHRA EQ NEQ LT LTU GE GEU.
  - Result registered at the issue edge; alu_ready=1 on the next cycle (latency 1).
  - Shift amount is val2[log2(XLEN)-1:0]; upper bits are ignored.
  - SHRA is arithmetic. Compare ops yield 1 or 0.
  - Unknown op yields 0 with alu_ready=1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on issue of MUL/MULH/MULHSU/MULHU.
  - IDLE -> DIV on issue of DIV/DIVU/REM/REMU, except special cases.
  - MUL and DIV each iterate exactly XLEN cycles (counter 0..XLEN-1), then -> DONE.
  - DONE: registers the final sign-corrected result, asserts alu_ready, -> IDLE.
  - M-op latency is XLEN+2 cycles from the issue edge to alu_ready high. XLEN=32 gives 34.
  - alu_accept is low in MUL, DIV and DONE.
- Signed handling:
  - Operand magnitudes are latched at issue, with result-sign flags.
  - MUL keeps a 2*XLEN product. MUL returns the low half; MULH, MULHSU, MULHU return the high half.
  - MULHSU treats val1 as signed and val2 as unsigned.
  - DIV/REM signs follow RISC-V: remainder takes the dividend sign.
- Division special cases resolve at issue with latency 1, and no FSM entry:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> val1.
  - Signed overflow (val1 = -2^(XLEN-1), val2 = -1): DIV -> val1; REM -> 0.
- alu_ready is 0 in every cycle not listed above.
- Flush (with rdy high):
  - state -> IDLE, counter -> 0, alu_ready -> 0 at that edge.
  - An in-flight M op is discarded.
  - An op presented in the flush cycle is dropped.
  - alu_res and alu_id hold.
  - Flush during DONE suppresses that result.
- Reset mid-iteration aborts immediately to the reset values.
- alu_id always equals the id latched at issue of the op whose result is presented.

Decomposition:
- global_params gains ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU codes, with ALU_OP_WIDTH raised to 5.
- FSM state encoding is local to alu_md.
- Sub-module alu_md_iter holds the shared iterative shift-add multiplier / restoring divider:
  - inputs: start, mode, magnitudes
  - outputs: 2*XLEN product or quotient/remainder, plus a done strobe.
- alu_md keeps base-op evaluation, special-case detection, sign correction, FSM and output registers.

Test Plan:
- ADD 0x7FFFFFFF+1 id 3 -> next cycle alu_ready=1, res 0x80000000, id 3; SHRA 0x80000000 by val2=0x21 -> 0xC0000000 (shift by 1).
- MULH -7 * 3 id 5 -> alu_accept low for 33 cycles; alu_ready at issue+34; res 0xFFFFFFFF; MUL same operands -> 0xFFFFFFEB.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0, both latency 1.
- Start DIVU 100/7, assert flush at iteration 10 -> no alu_ready ever for it; alu_accept high the next cycle; following ADD 1+2 returns 3 at latency 1.
- Hold rdy low for 5 cycles mid-MUL -> completion delayed exactly 5 cycles with the correct result; rdy low while alu_ready=1 -> pulse persists until rdy returns.
- Drive rst_n low mid-DIV between clock edges -> alu_ready, alu_res, alu_id go to 0 immediately; alu_accept=1 after release.
